// File: rtl/adc_acquisition_sequencer.sv
// adc_acquisition_sequencer: configures the ADC, waits for settling, samples until a code is stable or the budget runs out
module adc_acquisition_sequencer #(
  parameter int DATA_W          = 16,
  parameter int SETTLE_CYCLES   = 1024,
  parameter int SAMPLE_INTERVAL = 256,
  parameter int STABLE_COUNT    = 4,
  parameter int MAX_SAMPLES     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              req_algorithm,
  input  logic [1:0]        req_format,
  input  logic [DATA_W-1:0] adc_outputs,
  output logic              algorithm_select,
  output logic [1:0]        bin_bcd_select,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_timeout,
  output logic              result_valid,
  input  logic              result_ready
);
  localparam int WMAX = SETTLE_CYCLES > SAMPLE_INTERVAL ? SETTLE_CYCLES : SAMPLE_INTERVAL;
  localparam int WW = $clog2(WMAX + 1);
  localparam int SW = $clog2(MAX_SAMPLES + 1);
  localparam logic [WW-1:0] SETTLE_LAST = WW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] INTERVAL_LAST = WW'(SAMPLE_INTERVAL > 1 ? SAMPLE_INTERVAL - 2 : 0);
  localparam logic [SW-1:0] STABLE_N = SW'(STABLE_COUNT);
  localparam logic [SW-1:0] MAX_N = SW'(MAX_SAMPLES);
  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, INTERVAL, DONE} state_t;
  state_t            r_state, w_state_next;
  logic              r_alg, r_timeout;
  logic [1:0]        r_fmt;
  logic [DATA_W-1:0] r_result, r_last;
  logic [WW-1:0]     r_wait;
  logic [SW-1:0]     r_sample_cnt, r_match_cnt, w_sample_next, w_match_next;
  logic              w_accept, w_stable;
  assign algorithm_select = r_alg;
  assign bin_bcd_select   = r_fmt;
  assign result           = r_result;
  assign result_timeout   = r_timeout;
  assign result_valid     = r_state == DONE;
  assign busy             = r_state != IDLE;
  // next state and sample qualification; abort overrides every transition
  always_comb begin
    w_accept      = r_state == IDLE && start && !abort;
    w_sample_next = r_sample_cnt + 1'b1;
    w_match_next  = (r_sample_cnt == '0 || adc_outputs != r_last) ? SW'(1) : r_match_cnt + 1'b1;
    w_stable      = w_match_next == STABLE_N;
    w_state_next  = r_state;
    case (r_state)
      IDLE:     w_state_next = w_accept ? SETTLE : IDLE;
      SETTLE:   w_state_next = r_wait == SETTLE_LAST ? SAMPLE : SETTLE;
      SAMPLE:   w_state_next = (w_stable || w_sample_next == MAX_N) ? DONE :
                               SAMPLE_INTERVAL == 1 ? SAMPLE : INTERVAL;
      INTERVAL: w_state_next = r_wait == INTERVAL_LAST ? SAMPLE : INTERVAL;
      DONE:     w_state_next = result_ready ? IDLE : DONE;
      default:  w_state_next = IDLE;
    endcase
    if (abort) w_state_next = IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_state_next;
  end
  // configuration latch, wait/sample counters and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alg        <= 1'b0;
      r_fmt        <= 2'b00;
      r_result     <= '0;
      r_timeout    <= 1'b0;
      r_last       <= '0;
      r_wait       <= '0;
      r_sample_cnt <= '0;
      r_match_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_alg        <= req_algorithm;
        r_fmt        <= req_format;
        r_sample_cnt <= '0;
        r_match_cnt  <= '0;
      end
      r_wait <= (w_state_next == r_state && (r_state == SETTLE || r_state == INTERVAL)) ? r_wait + 1'b1 : '0;
      if (r_state == SAMPLE && !abort) begin
        r_last       <= adc_outputs;
        r_sample_cnt <= w_sample_next;
        r_match_cnt  <= w_match_next;
      end
      if (r_state == SAMPLE && w_state_next == DONE) begin
        r_result  <= adc_outputs;
        r_timeout <= !w_stable;
      end
    end
  end
endmodule

// File: tb/tb_adc_acquisition_sequencer.sv
// tb_adc_acquisition_sequencer: scoreboard bench for the acquisition sequencer
module tb_adc_acquisition_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        req_algorithm = 1'b0;
  logic [1:0]  req_format = 2'b00;
  logic [15:0] adc_outputs = '0;
  logic        result_ready = 1'b0;
  logic        algorithm_select, busy, result_timeout, result_valid;
  logic [1:0]  bin_bcd_select;
  logic [15:0] result;
  typedef struct {
    logic [15:0] res;
    logic        to;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  logic prev_valid = 1'b0;
  adc_acquisition_sequencer #(
    .DATA_W(16), .SETTLE_CYCLES(8), .SAMPLE_INTERVAL(4), .STABLE_COUNT(3), .MAX_SAMPLES(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .req_algorithm(req_algorithm), .req_format(req_format), .adc_outputs(adc_outputs),
    .algorithm_select(algorithm_select), .bin_bcd_select(bin_bcd_select), .busy(busy),
    .result(result), .result_timeout(result_timeout), .result_valid(result_valid),
    .result_ready(result_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [15:0] adc_at(input int mode, input logic [15:0] base, input int r);
    case (mode)
      1: return base + 16'(r);
      2: return r <= 10 ? base : base + 16'd1;
      3: return r <= 25 ? base + 16'(r) : 16'h3000;
      default: return base;
    endcase
  endfunction
  always @(negedge clk) begin
    if (result_valid && !prev_valid) begin
      if (sb.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else begin
        m_e = sb.pop_front();
        check("result", 32'(result), 32'(m_e.res));
        check("timeout", 32'(result_timeout), 32'(m_e.to));
        check("latency", 32'(cyc - t0), 32'(m_e.lat));
      end
    end
    prev_valid <= result_valid;
  end
  task automatic acquire(input logic alg, input logic [1:0] fmt, input int mode, input logic [15:0] base,
                         input logic [15:0] er, input logic et, input int lat);
    sb.push_back('{er, et, lat});
    req_algorithm = alg;
    req_format    = fmt;
    result_ready  = 1'b1;
    adc_outputs   = adc_at(mode, base, 0);
    start         = 1'b1;
    t0            = cyc;
    for (int r = 1; r <= lat + 1; r++) begin
      @(negedge clk);
      start = 1'b0;
      adc_outputs = adc_at(mode, base, r);
      if (r == 1) begin
        check("alg_latched", 32'(algorithm_select), 32'(alg));
        check("fmt_latched", 32'(bin_bcd_select), 32'(fmt));
        check("busy_start", 32'(busy), 32'd1);
      end
    end
    check("valid_one_cycle", 32'(result_valid), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
    check("drain", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_alg", 32'(algorithm_select), 32'd0);
    check("rst_fmt", 32'(bin_bcd_select), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);
    acquire(1'b1, 2'b01, 0, 16'h0123, 16'h0123, 1'b0, 18);
    acquire(1'b0, 2'b10, 1, 16'h1000, 16'h1025, 1'b1, 38);
    acquire(1'b1, 2'b11, 2, 16'h00A0, 16'h00A1, 1'b0, 22);
    acquire(1'b0, 2'b00, 3, 16'h2000, 16'h3000, 1'b0, 38);
    sb.push_back('{16'h0456, 1'b0, 18});
    result_ready  = 1'b0;
    req_algorithm = 1'b0;
    req_format    = 2'b10;
    adc_outputs   = 16'h0456;
    start         = 1'b1;
    t0            = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(result_valid), 32'd1);
      check("hold_result", 32'(result), 32'h0456);
      start = i == 3;
      req_algorithm = 1'b1;
      req_format = 2'b11;
      @(negedge clk);
    end
    check("done_start_alg", 32'(algorithm_select), 32'd0);
    check("done_start_fmt", 32'(bin_bcd_select), 32'd2);
    check("done_busy", 32'(busy), 32'd1);
    check("drain_hold", 32'(sb.size()), 32'd0);
    result_ready = 1'b1;
    @(negedge clk);
    check("hs_busy", 32'(busy), 32'd0);
    check("hs_valid", 32'(result_valid), 32'd0);
    check("hs_result_held", 32'(result), 32'h0456);
    req_algorithm = 1'b1;
    req_format    = 2'b11;
    adc_outputs   = 16'h0777;
    start         = 1'b1;
    for (int r = 1; r <= 12; r++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_alg_held", 32'(algorithm_select), 32'd1);
    check("abort_fmt_held", 32'(bin_bcd_select), 32'd3);
    check("abort_result_held", 32'(result), 32'h0456);
    repeat (30) @(negedge clk);
    acquire(1'b0, 2'b01, 0, 16'h0888, 16'h0888, 1'b0, 18);
    req_algorithm = 1'b1;
    req_format    = 2'b10;
    adc_outputs   = 16'h0999;
    start         = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_alg", 32'(algorithm_select), 32'd0);
    check("mid_rst_fmt", 32'(bin_bcd_select), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_timeout", 32'(result_timeout), 32'd0);
    repeat (30) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);
    check("final_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/adc_acquisition_sequencer.md
Name: adc_acquisition_sequencer

Overview:
- Sequences the dual-algorithm PWM ADC system (ramp/SAR) on request.
- Drives algorithm_select and bin_bcd_select, waits a settle period, then samples adc_outputs periodically until a code is stable for STABLE_COUNT consecutive samples, or until a sample budget is exhausted.
- Returns the qualified result over a valid/ready handshake.
- Sits between system control logic and the ADC system top level.

Parameters:
- DATA_W, 16, width of the ADC result bus.
- SETTLE_CYCLES, 1024, cycles to wait after applying a configuration before the first sample (≥1).
- SAMPLE_INTERVAL, 256, cycles between consecutive samples (≥1; 1 = back-to-back).
- STABLE_COUNT, 4, consecutive identical samples needed to qualify a result (1..MAX_SAMPLES).
- MAX_SAMPLES, 32, sample budget before a timeout result is returned (≥1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  acquisition request pulse; sampled only in IDLE.
- abort  input  1  cancel any acquisition; return to IDLE.
- req_algorithm  input  1  requested algorithm (0 ramp, 1 SAR); latched on accepted start.
- req_format  input  2  requested bin/BCD select; latched on accepted start.
- adc_outputs  input  DATA_W  conversion code from the ADC system.
- algorithm_select  output  1  to the ADC system.
- bin_bcd_select  output  2  to the ADC system.
- busy  output  1  high whenever state ≠ IDLE.
- result  output  DATA_W  qualified code.
- result_timeout  output  1  1 = budget exhausted without stability.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (synchronous, active-high): state IDLE; algorithm_select=0; bin_bcd_select=2'b00; result=0; result_timeout=0; result_valid=0; busy=0; all counters=0.
- States: IDLE, SETTLE, SAMPLE, INTERVAL, DONE.
- IDLE:
  - When start=1 and abort=0, latch req_algorithm→algorithm_select and req_format→bin_bcd_select, clear counters, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE: occupies exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE: one cycle; capture adc_outputs into last_sample and increment sample_cnt.
  - match_cnt rule: first sample of a run, or adc_outputs ≠ last_sample, sets match_cnt=1; otherwise match_cnt increments.
  - If the new match_cnt = STABLE_COUNT: go to DONE with result_timeout=0.
  - Else if the new sample_cnt = MAX_SAMPLES: go to DONE with result_timeout=1.
  - Else go to INTERVAL, or to SAMPLE directly if SAMPLE_INTERVAL=1.
  - If stability and budget exhaustion occur on the same sample, stability wins (result_timeout=0).
- INTERVAL: occupies SAMPLE_INTERVAL-1 cycles, then SAMPLE.
- DONE:
  - result = captured sample, result_valid=1; both held stable until result_ready=1.
  - On handshake, next cycle result_valid=0 and state IDLE.
  - result_ready is ignored outside DONE.
- Latency (constant input, start accepted at cycle 0): result_valid rises at cycle 2 + SETTLE_CYCLES + (STABLE_COUNT-1)·SAMPLE_INTERVAL.
- start is ignored while busy; no queueing.
- abort has priority over every other event, including start and a simultaneous handshake. Next cycle: state IDLE, result_valid=0. result, result_timeout, algorithm_select and bin_bcd_select hold their values.
- Reset mid-operation behaves as abort, and additionally applies all reset values.
- algorithm_select and bin_bcd_select change only on an accepted start or on reset.
- Counters are sized with clog2 of their maximum and saturate-free by construction; no wrap-around is possible within legal parameters.

Test Plan (SETTLE_CYCLES=8, SAMPLE_INTERVAL=4, STABLE_COUNT=3, MAX_SAMPLES=8):
- Reset, then idle 5 cycles -> algorithm_select=0, bin_bcd_select=00, busy=0, result_valid=0, result=0.
- start at cycle 0 with req_algorithm=1, req_format=01, adc_outputs held at 0x0123, result_ready=1 -> algorithm_select=1 and bin_bcd_select=01 at cycle 1; busy high cycles 1–18; result_valid=1 at cycle 18 only; result=0x0123, result_timeout=0.
- adc_outputs changes every cycle (incrementing) -> result_valid at cycle 38; result_timeout=1; result = value sampled at cycle 37.
- adc_outputs sequence per sample A,B,B,B -> qualifies on the 4th sample; result=B; result_valid at cycle 22.
- Result pending with result_ready=0 for 10 cycles -> result and result_valid stable throughout; a start pulse during DONE is ignored; ready=1 -> IDLE next cycle.
- abort at cycle 12 (INTERVAL), and separately reset at cycle 5 -> IDLE next cycle, result_valid never asserts; a new start after abort restarts the full settle.
